// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// the golden table of (~a | b) & (b | ~c), and the default input count.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  localparam int unsigned TT_DEFAULT_INPUTS = 3;
  localparam logic [7:0]  TT_EXPR_GOLDEN    = 8'hCD;

  // Number of truth-table rows for an n-input expression.
  function automatic int unsigned tt_rows(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_timer.sv
// Settle timer: loadable down-counter that flags expiry when it reaches zero.
// Loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles until expired.
module tt_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned    CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  LOAD_VAL = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps {a,b,c} through every combination, holds each for SETTLE_CYCLES, samples
// the external expression output and scores the captured table against EXPECTED.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned                N_INPUTS      = TT_DEFAULT_INPUTS,
  parameter int unsigned                SETTLE_CYCLES = 1,
  parameter logic [(1<<N_INPUTS)-1:0]   EXPECTED      = TT_EXPR_GOLDEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_INPUTS-1:0]      stim,
  input  logic                     dut_result,
  output logic                     busy,
  output logic                     row_valid,
  output logic [N_INPUTS-1:0]      row_index,
  output logic [(1<<N_INPUTS)-1:0] captured,
  output logic [N_INPUTS:0]        mismatch_cnt,
  output logic                     done,
  output logic                     pass
);

  localparam int unsigned           ROWS     = tt_rows(N_INPUTS);
  localparam logic [N_INPUTS-1:0]   LAST_ROW = '1;
  localparam logic [N_INPUTS-1:0]   STIM_ONE = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]     CNT_ONE  = (N_INPUTS + 1)'(1);

  tt_state_t             r_state;
  tt_state_t             w_next_state;
  logic [N_INPUTS-1:0]   r_stim;
  logic [ROWS-1:0]       r_captured;
  logic [N_INPUTS:0]     r_mismatch_cnt;

  logic w_start_sweep;
  logic w_last_row;
  logic w_row_miss;
  logic w_timer_clr;
  logic w_timer_load;
  logic w_timer_en;
  logic w_expired;

  assign w_last_row = (r_stim == LAST_ROW);
  assign w_row_miss = (dut_result != EXPECTED[r_stim]);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_timer_clr),
    .i_load   (w_timer_load),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_start_sweep = 1'b0;
    w_timer_clr   = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_en    = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state  = DRIVE;
          w_start_sweep = 1'b1;
          w_timer_load  = 1'b1;
        end else begin
          w_timer_clr   = 1'b1;
        end
      end
      DRIVE: begin
        if (w_expired) begin
          w_next_state = SAMPLE;
        end else begin
          w_timer_en   = 1'b1;
        end
      end
      SAMPLE: begin
        if (w_last_row) begin
          w_next_state = DONE;
        end else begin
          w_next_state = DRIVE;
          w_timer_load = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Stimulus and scoring: the last row is found by compare, so stim never wraps
  // and stays on the final row while the result is held in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim         <= '0;
      r_captured     <= '0;
      r_mismatch_cnt <= '0;
    end else if (w_start_sweep) begin
      r_stim         <= '0;
      r_captured     <= '0;
      r_mismatch_cnt <= '0;
    end else if (r_state == SAMPLE) begin
      r_captured[r_stim] <= dut_result;
      if (w_row_miss) begin
        r_mismatch_cnt <= r_mismatch_cnt + CNT_ONE;
      end
      if (!w_last_row) begin
        r_stim <= r_stim + STIM_ONE;
      end
    end
  end

  assign stim         = r_stim;
  assign busy         = (r_state == DRIVE) || (r_state == SAMPLE);
  assign row_valid    = (r_state == SAMPLE);
  assign row_index    = (r_state == SAMPLE) ? r_stim : '0;
  assign captured     = r_captured;
  assign mismatch_cnt = r_mismatch_cnt;
  assign done         = (r_state == DONE);
  assign pass         = (r_state == DONE) && (r_mismatch_cnt == '0);

endmodule
